multi_light_controller: RTL and testbench

MULTI_LIGHT_CONTROLLER -- requirements
Module: multi_light_controller

---
 rtl/multi_light_controller.sv | 115 +++++++++++
 tb/tb_multi_light_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_light_controller
// Purpose  : Per-channel button synchronizer, debouncer and toggle/momentary
//            light FSM. Optional auto-off timer enabled by LIGHT_CTRL_AUTO_OFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multi_light_controller #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    input  logic [CHANNELS-1:0] mode,
    input  logic                all_off,
    output logic [CHANNELS-1:0] light,
    output logic [CHANNELS-1:0] press_pulse
);

    localparam int CNT_W = 8;
    localparam int TMR_W = 16;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;
        state_t           state_q;
        state_t           state_d;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
        logic [TMR_W-1:0] tmr_q;
        logic [TMR_W-1:0] tmr_d;
        logic             expire;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
                pulse_q  <= 1'b0;
                state_q  <= ST_OFF;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
                tmr_q    <= '0;
`endif
            end else begin
                sync1_q  <= button[g];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                pulse_q  <= pulse_d;
                state_q  <= state_d;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
                tmr_q    <= tmr_d;
`endif
            end
        end

        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            pulse_d  = 1'b0;
            state_d  = state_q;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
            tmr_d    = '0;
            expire   = (({1'b0, tmr_q} + 17'd1) == 17'(TIMEOUT_CYCLES));
`endif
            // Accept on the edge the mismatch run would reach the threshold.
            if (sync2_q != stable_q) begin
                if (({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_CYCLES)) begin
                    stable_d = sync2_q;
                    pulse_d  = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            if (all_off) begin
                state_d = ST_OFF;
            end else if (mode[g]) begin
                state_d = stable_d ? ST_ON : ST_OFF;
            end else if (pulse_d) begin
                state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
            end else if (state_q == ST_ON && expire) begin
                state_d = ST_OFF;
`endif
            end

`ifdef LIGHT_CTRL_AUTO_OFF_EN
            // Timer counts only uninterrupted toggle-mode ON time.
            if (state_q == ST_ON && state_d == ST_ON && !mode[g] && !pulse_d) begin
                tmr_d = tmr_q + 1'b1;
            end
`endif
        end

        assign light[g]       = (state_q == ST_ON);
        assign press_pulse[g] = pulse_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_light_controller
// Purpose  : Vector table, directed corner sequences and random stimulus
//            checked against a history-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_light_controller;

    localparam int CH  = 4;
    localparam int DEB = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] button;
    logic [CH-1:0] mode;
    logic          all_off;
    logic [CH-1:0] light;
    logic [CH-1:0] press_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    multi_light_controller #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .mode       (mode),
        .all_off    (all_off),
        .light      (light),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    // Reference: button reaches the debouncer two edges late; stable flips
    // once the last DEB debouncer samples all disagree with it.
    logic [CH-1:0] m_dly1, m_dly2, m_stable, m_light, m_pulse;
    logic [31:0]   m_hist [CH];
    int            m_on   [CH];

    task automatic model_reset();
        m_dly1 = '0; m_dly2 = '0; m_stable = '0; m_light = '0; m_pulse = '0;
        for (int i = 0; i < CH; i++) begin
            m_hist[i] = '0;
            m_on[i]   = 0;
        end
    endtask

    task automatic model_edge();
        logic [31:0]   mask;
        logic [CH-1:0] nst, prs, nl;
        mask = (32'd1 << DEB) - 32'd1;
        for (int i = 0; i < CH; i++) begin
            m_hist[i] = {m_hist[i][30:0], m_dly2[i]};
            nst[i] = m_stable[i];
            prs[i] = 1'b0;
            if ((m_hist[i] & mask) == (m_stable[i] ? 32'd0 : mask)) begin
                nst[i] = ~m_stable[i];
                prs[i] = nst[i];
            end
            if (all_off)      nl[i] = 1'b0;
            else if (mode[i]) nl[i] = nst[i];
            else if (prs[i])  nl[i] = ~m_light[i];
            else              nl[i] = m_light[i];
`ifdef LIGHT_CTRL_AUTO_OFF_EN
            if (!all_off && !mode[i] && !prs[i] && m_light[i] && (m_on[i] + 1 >= TMO))
                nl[i] = 1'b0;
`endif
            m_on[i] = (nl[i] && m_light[i] && !mode[i] && !prs[i]) ? m_on[i] + 1 : 0;
        end
        m_dly2   = m_dly1;
        m_dly1   = button;
        m_stable = nst;
        m_light  = nl;
        m_pulse  = prs;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare away from the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        chk("model_light", {28'd0, light}, {28'd0, m_light});
        chk("model_pulse", {28'd0, press_pulse}, {28'd0, m_pulse});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_light", {28'd0, light}, 32'd0);
        chk("rst_pulse", {28'd0, press_pulse}, 32'd0);
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [CH-1:0] btn;
        logic [CH-1:0] md;
        logic          aoff;
        int            n;
        logic [CH-1:0] xl;
        logic [CH-1:0] xp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        reset = 1'b1; button = '0; mode = '0; all_off = 1'b0;
        model_reset();
        #2;
        do_reset();

        // toggle latency, second press, bounce rejection, all_off priority
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 5, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 1, 4'b0001, 4'b0001};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 1, 4'b0001, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 5, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b0001, 4'b0000, 1'b0, 1, 4'b0000, 4'b0001};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 3, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 2, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0010, 4'b0000, 1'b0, 3, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0101, 4'b0000, 1'b0, 5, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0101, 4'b0000, 1'b0, 1, 4'b0101, 4'b0101};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0101, 4'b0000};
        tbl[14] = '{4'b0010, 4'b0000, 1'b0, 5, 4'b0101, 4'b0000};
        tbl[15] = '{4'b0010, 4'b0000, 1'b1, 1, 4'b0000, 4'b0010};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 8, 4'b0000, 4'b0000};

        for (int v = 0; v < 17; v++) begin
            button = tbl[v].btn; mode = tbl[v].md; all_off = tbl[v].aoff;
            for (int k = 0; k < tbl[v].n; k++) begin
                tick();
                chk($sformatf("tbl%0d_light", v), {28'd0, light}, {28'd0, tbl[v].xl});
                chk($sformatf("tbl%0d_pulse", v), {28'd0, press_pulse}, {28'd0, tbl[v].xp});
            end
        end
        all_off = 1'b0;

        // momentary follow, then switch to toggle while ON
        do_reset();
        mode = 4'b0100; button = 4'b0100;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("mom_on_e%0d", e), {31'd0, light[2]}, {31'd0, (e >= 6)});
        end
        button = 4'b0000;
        for (int e = 11; e <= 16; e++) begin
            tick();
            chk($sformatf("mom_off_e%0d", e), {31'd0, light[2]}, {31'd0, (e <= 15)});
        end
        button = 4'b0100;
        repeat (6) tick();
        chk("mom_reon", {31'd0, light[2]}, 32'd1);
        mode = 4'b0000;
        tick();
        chk("modesw_hold", {31'd0, light[2]}, 32'd1);
        button = 4'b0000;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk("modesw_release", {31'd0, light[2]}, 32'd1);
        end

        // async reset mid-debounce, then held button after release
        do_reset();
        button = 4'b1111;
        repeat (6) tick();
        chk("all_on", {28'd0, light}, 32'hF);
        button = 4'b0000;
        repeat (8) tick();
        button = 4'b1000;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_light", {28'd0, light}, 32'd0);
        tick();
        chk("inrst_light", {28'd0, light}, 32'd0);
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("postrst_e%0d", e), {31'd0, light[3]}, {31'd0, (e == 6)});
        end
        chk("postrst_pulse", {31'd0, press_pulse[3]}, 32'd1);

        // auto-off timing, or persistence without the timer
        do_reset();
        button = 4'b0001;
        repeat (6) tick();
        chk("ao_on", {31'd0, light[0]}, 32'd1);
        button = 4'b0000;
`ifdef LIGHT_CTRL_AUTO_OFF_EN
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("ao_e%0d", e), {31'd0, light[0]}, {31'd0, (e < 16)});
        end
`else
        for (int e = 1; e <= 100; e++) begin
            tick();
            chk("persist", {31'd0, light[0]}, 32'd1);
        end
`endif
        do_reset();
        button = 4'b0001;
        repeat (6) tick();
        button = 4'b0000;
        repeat (4) tick();
        button = 4'b0001;
        for (int e = 5; e <= 10; e++) begin
            tick();
            chk($sformatf("press10_e%0d", e), {31'd0, light[0]}, {31'd0, (e < 10)});
        end
        chk("press10_pulse", {31'd0, press_pulse[0]}, 32'd1);

        // random bouncy traffic against the model
        do_reset();
        button = '0; mode = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0)  button[i] = ~button[i];
                if ($urandom_range(0, 59) == 0) mode[i]   = ~mode[i];
            end
            all_off = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) begin
                all_off = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
